// File: rtl/lfc_pkg.sv
// Shared types and constants for the line-following controller.
package lfc_pkg;

   localparam int unsigned TIMER_W = 32;
   localparam int unsigned BYTE_W  = 8;

   typedef enum logic [3:0] {
      IDLE, FOLLOW, CROSS_WAIT, TURN_R, TURN_L, STRAIGHT, UTURN_1, UTURN_2, REPORT
   } lfc_state_e;

   localparam logic [BYTE_W-1:0] CMD_RIGHT    = 8'd1;
   localparam logic [BYTE_W-1:0] CMD_LEFT     = 8'd2;
   localparam logic [BYTE_W-1:0] CMD_STRAIGHT = 8'd3;
   localparam logic [BYTE_W-1:0] CMD_UTURN    = 8'd4;

   localparam logic [BYTE_W-1:0] RPT_RIGHT     = 8'd11;
   localparam logic [BYTE_W-1:0] RPT_LEFT      = 8'd21;
   localparam logic [BYTE_W-1:0] RPT_STRAIGHT  = 8'd31;
   localparam logic [BYTE_W-1:0] RPT_UTURN     = 8'd41;
   localparam logic [BYTE_W-1:0] RPT_BAD_CMD   = 8'hEE;
   localparam logic [BYTE_W-1:0] RPT_LINE_LOST = 8'hF0;

   typedef struct packed {
      logic l_en;
      logic l_dir;
      logic r_en;
      logic r_dir;
   } motor_cmd_t;

   // Left forward is dir 1, right forward is dir 0.
   localparam motor_cmd_t MOTOR_OFF     = '{l_en: 1'b0, l_dir: 1'b1, r_en: 1'b0, r_dir: 1'b0};
   localparam motor_cmd_t MOTOR_FWD     = '{l_en: 1'b1, l_dir: 1'b1, r_en: 1'b1, r_dir: 1'b0};
   localparam motor_cmd_t MOTOR_PIVOT_R = '{l_en: 1'b1, l_dir: 1'b1, r_en: 1'b1, r_dir: 1'b1};
   localparam motor_cmd_t MOTOR_PIVOT_L = '{l_en: 1'b1, l_dir: 1'b0, r_en: 1'b1, r_dir: 1'b0};
   localparam motor_cmd_t MOTOR_STEER_L = '{l_en: 1'b0, l_dir: 1'b1, r_en: 1'b1, r_dir: 1'b0};
   localparam motor_cmd_t MOTOR_STEER_R = '{l_en: 1'b1, l_dir: 1'b1, r_en: 1'b0, r_dir: 1'b0};

endpackage

// File: rtl/lfc_cmd_fifo.sv
// Command byte FIFO with registered full/empty/count and first-word-fall-through read.
module lfc_cmd_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count_n;
   logic             do_push, do_pop;

   // A push on a full FIFO is allowed when a pop frees the slot in the same cycle.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;
   assign count_n = count + CNT_W'(do_push) - CNT_W'(do_pop);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_n;
         full  <= (count_n == CNT_W'(DEPTH));
         empty <= (count_n == '0);
      end
   end

endmodule

// File: rtl/line_follow_ctrl.sv
// Line-following robot controller: follows a line, executes queued turn commands at crossings.
// Optional line-lost watchdog enabled by defining LFC_WATCHDOG_EN.
module line_follow_ctrl
   import lfc_pkg::*;
#(
   parameter int unsigned NUM_SENS     = 3,
   parameter int unsigned CMD_DEPTH    = 4,
   parameter int unsigned T_FOLLOW_MAX = 2000000,
   parameter int unsigned T_CROSS      = 8000000,
   parameter int unsigned T_TURN       = 8000000,
   parameter int unsigned T_UTURN      = 20000000
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_SENS-1:0]          sensors,
   input  logic [7:0]                   rx_data,
   input  logic                         rx_valid,
   output logic                         rx_ready,
   output logic [7:0]                   tx_data,
   output logic                         tx_valid,
   input  logic                         tx_ready,
   output logic                         motor_l_en,
   output logic                         motor_l_dir,
   output logic                         motor_r_en,
   output logic                         motor_r_dir,
   output logic                         busy,
   output logic [$clog2(CMD_DEPTH):0]   cmd_count
);

   localparam int unsigned HALF = NUM_SENS / 2;

   lfc_state_e         state_q, state_d;
   logic [TIMER_W-1:0] timer_q;
   logic               fifo_full, fifo_empty, pop_c, flush_c;
   logic [BYTE_W-1:0]  fifo_head, rpt_code_c, tx_data_q;
   logic               tx_valid_q, busy_q;
   motor_cmd_t         motor_d, motor_q;
   logic               any_left, any_right, centre, any_set, all_ones;

   assign any_left  = |sensors[HALF-1:0];
   assign any_right = |sensors[NUM_SENS-1:HALF+1];
   assign centre    = sensors[HALF];
   assign any_set   = |sensors;
   assign all_ones  = &sensors;

   lfc_cmd_fifo #(.DEPTH(CMD_DEPTH), .WIDTH(BYTE_W)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush_c),
      .push    (rx_valid && !fifo_full),
      .wr_data (rx_data),
      .pop     (pop_c),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (cmd_count)
   );

`ifdef LFC_WATCHDOG_EN
   logic [TIMER_W-1:0] lost_q;
   logic               wd_abort_q, wd_abort_d, tracking_c, line_lost_c;

   assign tracking_c  = state_q inside {FOLLOW, TURN_R, TURN_L, STRAIGHT, UTURN_1, UTURN_2};
   assign line_lost_c = tracking_c && !any_set && (lost_q >= TIMER_W'(T_FOLLOW_MAX - 1));

   // Consecutive all-zero sensor cycles while tracking the line.
   always_ff @(posedge clk) begin
      if (reset) begin
         lost_q     <= '0;
         wd_abort_q <= 1'b0;
      end else begin
         wd_abort_q <= wd_abort_d;
         if (tracking_c && !any_set) begin
            if (lost_q != '1) lost_q <= lost_q + TIMER_W'(1);
         end else begin
            lost_q <= '0;
         end
      end
   end
`endif

   always_comb begin
      state_d    = state_q;
      pop_c      = 1'b0;
      flush_c    = 1'b0;
      rpt_code_c = '0;
`ifdef LFC_WATCHDOG_EN
      wd_abort_d = wd_abort_q;
`endif
      case (state_q)
         IDLE:       if (!fifo_empty) state_d = FOLLOW;
         FOLLOW: begin
            if (all_ones) state_d = CROSS_WAIT;
            else if (timer_q > TIMER_W'(T_FOLLOW_MAX)) state_d = IDLE;
         end
         CROSS_WAIT: begin
            if (timer_q >= TIMER_W'(T_CROSS - 1)) begin
               pop_c = !fifo_empty;
               if (fifo_empty) state_d = IDLE;
               else begin
                  case (fifo_head)
                     CMD_RIGHT:    state_d = TURN_R;
                     CMD_LEFT:     state_d = TURN_L;
                     CMD_STRAIGHT: state_d = STRAIGHT;
                     CMD_UTURN:    state_d = UTURN_1;
                     default: begin
                        state_d    = REPORT;
                        rpt_code_c = RPT_BAD_CMD;
                     end
                  endcase
               end
            end
         end
         TURN_R: if (any_set && timer_q > TIMER_W'(T_TURN)) begin
            state_d    = REPORT;
            rpt_code_c = RPT_RIGHT;
         end
         TURN_L: if (any_set && timer_q > TIMER_W'(T_TURN)) begin
            state_d    = REPORT;
            rpt_code_c = RPT_LEFT;
         end
         STRAIGHT: if (any_set && timer_q > TIMER_W'(T_FOLLOW_MAX)) begin
            state_d    = REPORT;
            rpt_code_c = RPT_STRAIGHT;
         end
         UTURN_1: if (any_set && timer_q > TIMER_W'(T_UTURN)) state_d = UTURN_2;
         UTURN_2: if (any_set && timer_q > TIMER_W'(T_UTURN)) begin
            state_d    = REPORT;
            rpt_code_c = RPT_UTURN;
         end
         REPORT: if (tx_ready) begin
            state_d = fifo_empty ? IDLE : FOLLOW;
`ifdef LFC_WATCHDOG_EN
            if (wd_abort_q) state_d = IDLE;
            wd_abort_d = 1'b0;
`endif
         end
         default: state_d = IDLE;
      endcase
`ifdef LFC_WATCHDOG_EN
      // Line lost overrides any normal transition and drops queued commands.
      if (line_lost_c) begin
         state_d    = REPORT;
         rpt_code_c = RPT_LINE_LOST;
         pop_c      = 1'b0;
         flush_c    = 1'b1;
         wd_abort_d = 1'b1;
      end
`endif
      case (state_d)
         FOLLOW: begin
            if (any_left && !centre && !any_right)      motor_d = MOTOR_STEER_L;
            else if (any_right && !centre && !any_left) motor_d = MOTOR_STEER_R;
            else                                        motor_d = MOTOR_FWD;
         end
         CROSS_WAIT, STRAIGHT:      motor_d = MOTOR_FWD;
         TURN_R, UTURN_1, UTURN_2:  motor_d = MOTOR_PIVOT_R;
         TURN_L:                    motor_d = MOTOR_PIVOT_L;
         default:                   motor_d = MOTOR_OFF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         motor_q    <= MOTOR_OFF;
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         motor_q    <= motor_d;
         tx_valid_q <= (state_d == REPORT);
         busy_q     <= (state_d != IDLE);
         if (state_d == REPORT && state_q != REPORT) tx_data_q <= rpt_code_c;
         if (state_d != state_q)  timer_q <= '0;
         else if (timer_q != '1)  timer_q <= timer_q + TIMER_W'(1);
      end
   end

   assign rx_ready    = !fifo_full;
   assign tx_valid    = tx_valid_q;
   assign tx_data     = tx_data_q;
   assign busy        = busy_q;
   assign motor_l_en  = motor_q.l_en;
   assign motor_l_dir = motor_q.l_dir;
   assign motor_r_en  = motor_q.r_en;
   assign motor_r_dir = motor_q.r_dir;

endmodule
